// File: rtl/pulse_stretch_sched.sv
// Round-robin scheduler sharing one stretched-pulse output among N_CH requesters.
// Requests latch into a depth-1 pending vector; a guard gap separates consecutive pulses.
module pulse_stretch_sched #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_CH-1:0]   req,
  input  logic [LEN_W-1:0]  stretch_len,
  input  logic              clr_drop,
  output logic              out_pulse,
  output logic [ID_W-1:0]   out_id,
  output logic              busy,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   drop_flag
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned CntW = (LEN_W > GapW) ? LEN_W : GapW;

  typedef enum logic [1:0] {StIdle, StStretch, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] drop_q, drop_d;

  logic            grant;
  logic            found;
  logic [ID_W-1:0] grant_id;
  logic [N_CH-1:0] grant_oh;
  logic [N_CH-1:0] clear_mask;
  logic [LEN_W-1:0] len_m1;
  int unsigned     idx;

  // Scan starts one past the last winner so every channel gets a turn.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    grant_oh = '0;
    idx      = 0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = (32'(last_q) + i) % N_CH;
      if (!found && pend_q[idx]) begin
        found         = 1'b1;
        grant_id      = ID_W'(idx);
        grant_oh[idx] = 1'b1;
      end
    end
  end

  assign grant      = (state_q == StIdle) && enable && found;
  assign clear_mask = grant ? grant_oh : '0;
  assign len_m1     = (stretch_len == '0) ? '0 : stretch_len - 1'b1;

  // A new request always wins over the grant clear for its own bit.
  always_comb begin
    pend_d = (pend_q & ~clear_mask) | req;
    drop_d = (clr_drop ? '0 : drop_q) | (req & pend_q & ~clear_mask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StStretch;
          cnt_d   = CntW'(len_m1);
          last_d  = grant_id;
          id_d    = grant_id;
        end
      end
      StStretch: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = StGap;
            cnt_d   = CntW'(GAP_CYCLES - 1);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= ID_W'(N_CH - 1);
      id_q    <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign out_pulse = (state_q == StStretch);
  assign busy      = (state_q != StIdle);
  assign out_id    = id_q;
  assign pending   = pend_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_pulse_stretch_sched.sv
// Directed bench for pulse_stretch_sched: a timeline model (grant edge + length) checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_pulse_stretch_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;
  localparam int unsigned LW  = 4;
  localparam int unsigned GAP = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [N-1:0]  req;
  logic [LW-1:0] stretch_len;
  logic          clr_drop;
  logic          out_pulse;
  logic [IDW-1:0] out_id;
  logic          busy;
  logic [N-1:0]  pending;
  logic [N-1:0]  drop_flag;

  int checks   = 0;
  int failures = 0;

  // Model: pulses are described by the edge index of their grant and their length.
  bit           m_valid = 1'b0;
  bit           m_has;
  int           m_e = 0;
  int           m_g;
  int           m_len;
  int           m_last;
  int           m_id;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_drop;

  pulse_stretch_sched #(
    .N_CH      (N),
    .ID_W      (IDW),
    .LEN_W     (LW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req        (req),
    .stretch_len(stretch_len),
    .clr_drop   (clr_drop),
    .out_pulse  (out_pulse),
    .out_id     (out_id),
    .busy       (busy),
    .pending    (pending),
    .drop_flag  (drop_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by the edge about to happen, using the inputs as they stand now.
  task automatic model_step();
    logic [N-1:0] mask;
    int sel;
    m_e++;
    if (rst) begin
      m_valid = 1'b1;
      m_has   = 1'b0;
      m_last  = N - 1;
      m_id    = 0;
      m_pend  = '0;
      m_drop  = '0;
    end else begin
      mask = '0;
      sel  = -1;
      if (enable && m_pend != '0 && (!m_has || m_e >= m_g + m_len + GAP + 1)) begin
        for (int i = 1; i <= N; i++) begin
          if (sel < 0 && m_pend[(m_last + i) % N]) sel = (m_last + i) % N;
        end
        mask[sel] = 1'b1;
        m_last    = sel;
        m_id      = sel;
        m_has     = 1'b1;
        m_g       = m_e;
        m_len     = (stretch_len == '0) ? 1 : int'(stretch_len);
      end
      m_drop = (clr_drop ? '0 : m_drop) | (req & m_pend & ~mask);
      m_pend = (m_pend & ~mask) | req;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    if (m_valid) begin
      chk("cyc_out_pulse", int'(out_pulse), int'(m_has && m_e < m_g + m_len));
      chk("cyc_busy", int'(busy), int'(m_has && m_e < m_g + m_len + GAP));
      chk("cyc_out_id", int'(out_id), m_id);
      chk("cyc_pending", int'(pending), int'(m_pend));
      chk("cyc_drop_flag", int'(drop_flag), int'(m_drop));
    end
  endtask

  task automatic wait_pulse(input int max_cyc, output int lows);
    lows = 0;
    while (!out_pulse && lows < max_cyc) begin
      tick();
      lows++;
    end
  endtask

  task automatic measure_high(output int n);
    n = 0;
    while (out_pulse && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  initial begin
    int lows;
    int n;
    int b;
    rst = 1'b1; enable = 1'b1; req = '0; stretch_len = 4'd5; clr_drop = 1'b0;
    #2;
    tick();
    tick();
    chk("rst_out_pulse", int'(out_pulse), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop", int'(drop_flag), 0);
    rst = 1'b0;
    tick();

    // Round robin from reset: 0,1,2,3 with 3 low cycles between pulses.
    req = 4'b1111;
    tick();
    req = '0;
    chk("rr_pending_all", int'(pending), 4'b1111);
    for (int i = 0; i < 4; i++) begin
      wait_pulse(20, lows);
      chk("rr_started", int'(out_pulse), 1);
      if (i > 0) chk("rr_gap_low", lows, 3);
      chk("rr_id", int'(out_id), i);
      chk("rr_pending", int'(pending), (4'b1111 << (i + 1)) & 4'b1111);
      measure_high(n);
      chk("rr_len", n, 5);
    end
    wait_idle();

    // Single request on channel 1: two-cycle latency, 5-cycle pulse, 2 gap cycles.
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    chk("single_pending", int'(pending), 4'b0010);
    chk("single_no_pulse_yet", int'(out_pulse), 0);
    wait_pulse(20, lows);
    chk("single_latency", lows, 1);
    chk("single_id", int'(out_id), 1);
    measure_high(n);
    chk("single_len", n, 5);
    chk("single_id_hold", int'(out_id), 1);
    b = 0;
    while (busy && b < 20) begin
      b++;
      tick();
    end
    chk("single_gap_busy", b, 2);

    // Drop: channel 2 re-requests while pending; clr_drop clears; served exactly once.
    req = 4'b0001;
    tick();
    req = '0;
    wait_pulse(20, lows);
    chk("drop_ch0", int'(out_id), 0);
    req = 4'b0100;
    tick();
    tick();
    tick();
    req = '0;
    chk("drop_pending", int'(pending), 4'b0100);
    chk("drop_flag_set", int'(drop_flag), 4'b0100);
    clr_drop = 1'b1;
    tick();
    clr_drop = 1'b0;
    chk("drop_cleared", int'(drop_flag), 0);
    measure_high(n);
    wait_pulse(20, lows);
    chk("drop_ch2_id", int'(out_id), 2);
    measure_high(n);
    wait_pulse(12, lows);
    chk("drop_served_once", int'(out_pulse), 0);

    // Length edges: 0 -> 1 cycle, 15 -> 15 cycles, mid-pulse change ignored.
    stretch_len = 4'd0;
    req = 4'b1000;
    tick();
    req = '0;
    wait_pulse(20, lows);
    measure_high(n);
    chk("len0", n, 1);
    wait_idle();
    stretch_len = 4'd15;
    req = 4'b1000;
    tick();
    req = '0;
    wait_pulse(20, lows);
    measure_high(n);
    chk("len15", n, 15);
    wait_idle();
    stretch_len = 4'd7;
    req = 4'b1000;
    tick();
    req = '0;
    wait_pulse(20, lows);
    stretch_len = 4'd3;
    measure_high(n);
    chk("len_midchange", n, 7);
    wait_idle();

    // Enable gating: nothing granted while low; channel 0 goes first once raised.
    stretch_len = 4'd5;
    enable = 1'b0;
    req = 4'b0011;
    tick();
    req = '0;
    tick();
    tick();
    tick();
    chk("en_busy", int'(busy), 0);
    chk("en_no_pulse", int'(out_pulse), 0);
    chk("en_pending", int'(pending), 4'b0011);
    enable = 1'b1;
    tick();
    chk("en_pulse", int'(out_pulse), 1);
    chk("en_id0", int'(out_id), 0);
    measure_high(n);
    wait_pulse(20, lows);
    chk("en_id1", int'(out_id), 1);
    wait_idle();

    // Reset in the third stretch cycle with a pending request and a drop flag.
    req = 4'b0001;
    tick();
    req = '0;
    wait_pulse(20, lows);
    req = 4'b0100;
    tick();
    tick();
    chk("rstmid_pulse_before", int'(out_pulse), 1);
    chk("rstmid_drop_before", int'(drop_flag), 4'b0100);
    rst = 1'b1;
    clr_drop = 1'b0;
    tick();
    rst = 1'b0;
    req = '0;
    chk("rstmid_pulse", int'(out_pulse), 0);
    chk("rstmid_pending", int'(pending), 0);
    chk("rstmid_drop", int'(drop_flag), 0);
    chk("rstmid_busy", int'(busy), 0);
    req = 4'b0011;
    tick();
    req = '0;
    wait_pulse(20, lows);
    chk("rstmid_latency", lows, 1);
    chk("rstmid_first_ch0", int'(out_id), 0);
    wait_idle();
    wait_pulse(20, lows);
    chk("rstmid_then_ch1", int'(out_id), 1);
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_sched.md
Name: pulse_stretch_sched

Overview:
Round-robin scheduler that shares one pulse-stretch output among N_CH requesters. Each requester raises a single-cycle (or wider) request. The block latches the request and later grants the shared output. The output then drives a stretched pulse of programmable length, tagged with the winning channel ID. A fixed guard gap separates consecutive pulses. It sits between event sources and a single downstream strobe consumer.

Parameters:
N_CH, 4, number of requesting channels (2..16)
ID_W, 2, channel ID width; must be at least clog2(N_CH)
LEN_W, 4, width of the stretch_len input
GAP_CYCLES, 2, forced low cycles after each pulse, before IDLE (0 allowed)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  1 = new grants allowed; 0 = no new grants, an active pulse still completes
req  in  N_CH  per-channel request, sampled every clock edge
stretch_len  in  LEN_W  pulse length in cycles, captured at grant; 0 is treated as 1
clr_drop  in  1  clears all drop_flag bits
out_pulse  out  1  stretched output
out_id  out  ID_W  granted channel; valid while out_pulse=1, holds last value otherwise
busy  out  1  high when state is not IDLE
pending  out  N_CH  latched, unserved requests
drop_flag  out  N_CH  sticky: a request arrived while that channel was already pending

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_pulse=0, out_id=0, busy=0, pending=0, drop_flag=0, RR pointer last=N_CH-1 (channel 0 has first priority), counter=0.
  - req and clr_drop in a reset cycle are ignored.
  - Reset mid-pulse drops out_pulse low on the next cycle; no truncation artefact.
- Request latch: if req[k]=1 at an edge, pending[k]=1 after that edge.
  - If pending[k] was already 1 and is not being cleared by a grant at the same edge, drop_flag[k] is set and pending[k] stays 1. No queue depth beyond 1.
  - Grant clear and new req[k] at the same edge: set wins, pending[k]=1, no drop.
- clr_drop=1 clears all drop_flag bits. A new drop event at the same edge wins for its bit.
- FSM states: IDLE, STRETCH, GAP.
  - IDLE: if enable=1 and pending!=0, grant k = first set bit scanning last+1, last+2, … modulo N_CH. At that edge:
    - pending[k] cleared; last=k; out_id=k; out_pulse=1; state goes to STRETCH.
    - counter = max(stretch_len,1) - 1.
  - Grants use registered pending only.
- Latency: req high at edge t gives pending at t+1, and out_pulse first high after edge t+1 when idle and enabled. Two cycles, req-high cycle to first out_pulse cycle.
- STRETCH: out_pulse=1. If counter=0, out_pulse goes to 0 and state goes to GAP (GAP_CYCLES>0, counter=GAP_CYCLES-1) or IDLE (GAP_CYCLES=0). Else counter decrements.
  - out_pulse is high for exactly max(stretch_len,1) cycles.
  - Changes to stretch_len mid-pulse have no effect.
- GAP: out_pulse=0. When counter=0, go to IDLE; else decrement.
  - Minimum low time between pulses = GAP_CYCLES+1 (gap plus one IDLE arbitration cycle).
- A channel requesting while its own pulse is active re-latches and is served later by round robin. It is not ignored.
- enable=0 during STRETCH/GAP: the sequence completes and the block waits in IDLE; pending keeps accumulating.
- Counter width is LEN_W, or wider if clog2(GAP_CYCLES) > LEN_W.

Test Plan:
- Single request: stretch_len=5, GAP=2, req[1] one cycle high at cycle 10 → pending[1] at 11; out_pulse high cycles 12–16, out_id=1; busy through cycle 18; idle at 19.
- Round robin: req=4'b1111 one cycle → grants in order 0,1,2,3; each pulse 5 cycles; 3 low cycles between pulses; pending shrinks 1111→1110→1100→1000→0000.
- Drop and clear: req[2] high for 3 consecutive cycles while busy with channel 0 → pending[2]=1, drop_flag[2]=1; clr_drop pulse → drop_flag=0; channel 2 still served once.
- Length edges: stretch_len=0 → 1-cycle pulse; stretch_len=15 → 15 cycles. Changing stretch_len to 3 mid-pulse does not alter the current pulse.
- Enable gating: enable=0 with pending=0011 → no pulse and busy=0. Raise enable → channel 0 pulse starts the next cycle after sampling.
- Reset mid-pulse: rst at 3rd stretch cycle → next cycle out_pulse=0, pending=0, drop_flag=0. Then req[0] → channel 0 is granted first.
